// File: rtl/snn_image_loader.sv
// rtl/snn_image_loader.sv - unpacks a UART-received binary image into the SNN input RAM,
// starts the core and returns the classified digit as ASCII.
module snn_image_loader #(
  parameter int          NUM_PIXELS = 784,
  parameter logic [7:0]  ASCII_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  output logic       ram_we,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  input  logic       tx_rdy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [3:0] digit,
  output logic       busy
);

  localparam logic [9:0] LAST_ADDR = 10'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    LOAD,
    UNPACK,
    START,
    WAIT_DONE,
    SEND
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      ram_addr <= 10'd0;
      ram_data <= 1'b0;
      ram_we   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      digit    <= 4'd0;
    end else begin
      state    <= state_nxt;
      tx_start <= 1'b0;
      case (state)
        LOAD: begin
          // Bit 0 goes out immediately; the register keeps the remaining bits.
          if (rx_rdy) begin
            shreg    <= rx_data >> 1;
            bit_cnt  <= 3'd0;
            ram_we   <= 1'b1;
            ram_data <= rx_data[0];
          end
        end
        UNPACK: begin
          shreg    <= shreg >> 1;
          ram_data <= shreg[0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (ram_addr != LAST_ADDR)
            ram_addr <= ram_addr + 10'd1;
          if (bit_cnt == 3'd7)
            ram_we <= 1'b0;
        end
        START: ram_addr <= 10'd0;
        WAIT_DONE: begin
          if (core_done)
            digit <= core_digit;
        end
        SEND: begin
          if (tx_rdy) begin
            tx_start <= 1'b1;
            tx_data  <= 8'(ASCII_BASE + {4'b0000, digit});
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    // The transmit pulse cycle still counts as busy even though the FSM is back in LOAD.
    busy       = (state != LOAD) || tx_start;
    case (state)
      LOAD:      if (rx_rdy) state_nxt = UNPACK;
      UNPACK:    if (bit_cnt == 3'd7) state_nxt = (ram_addr == LAST_ADDR) ? START : LOAD;
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT_DONE;
      end
      WAIT_DONE: if (core_done) state_nxt = SEND;
      SEND:      if (tx_rdy) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

endmodule

// File: tb/tb_snn_image_loader.sv
// tb/tb_snn_image_loader.sv - scoreboard bench for snn_image_loader: RAM write stream,
// core handshake and ASCII result path.
module tb_snn_image_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       ram_we;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_rdy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] digit;
  logic       busy;

  snn_image_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_rdy     (tx_rdy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .digit      (digit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic [10:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  int          next_addr = 0;
  int          n_start = 0;
  logic        last_wr_783 = 1'b0;

  always @(negedge clk) begin : monitor
    logic [10:0] e;
    logic [7:0]  t;
    if (ram_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", 32'(ram_addr), -1);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e[10:1]));
        check("wr_data", 32'(ram_data), 32'(e[0]));
      end
    end
    if (core_start === 1'b1) begin
      n_start <= n_start + 1;
      check("start_after_last_wr", 32'(last_wr_783), 1);
      check("busy_at_start", 32'(busy), 1);
    end
    if (tx_start === 1'b1) begin
      if (exp_tx.size() == 0) begin
        check("tx_unexpected", 32'(tx_data), -1);
      end else begin
        t = exp_tx.pop_front();
        check("tx_data", 32'(tx_data), 32'(t));
      end
    end
    last_wr_783 <= (ram_we === 1'b1) && (ram_addr == 10'd783);
  end

  // Byte is sampled on the edge after it is driven; next byte follows exactly gap cycles later.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit drop);
    @(posedge clk) #1;
    rx_rdy  = 1'b1;
    rx_data = b;
    for (int k = 0; k < 8; k++) begin
      exp_wr.push_back({10'(next_addr), b[k]});
      next_addr = (next_addr == 783) ? 0 : next_addr + 1;
    end
    for (int i = 1; i < gap; i++) begin
      @(posedge clk) #1;
      rx_rdy = (drop && i == 3);
      if (rx_rdy) rx_data = 8'hFF;
    end
  endtask

  task automatic load_image(input bit rnd, input int gap, input int exp_starts);
    for (int k = 0; k < 98; k++)
      send_byte(rnd ? 8'($urandom) : 8'hA5, gap, (k == 0));
    repeat (4) @(posedge clk);
    #1;
    check("start_count", n_start, exp_starts);
    check("busy_wait_done", 32'(busy), 1);
  endtask

  task automatic classify(input logic [3:0] d, input int hold);
    tx_rdy = (hold == 0);
    @(posedge clk) #1;
    core_done  = 1'b1;
    core_digit = d;
    @(posedge clk) #1;
    core_done = 1'b0;
    check("digit_latched", 32'(digit), 32'(d));
    check("busy_send", 32'(busy), 1);
    exp_tx.push_back(8'(8'h30 + {4'b0000, d}));
    for (int i = 0; i < hold; i++) begin
      check("no_tx_backpressure", 32'(tx_start), 0);
      @(posedge clk) #1;
    end
    tx_rdy = 1'b1;
    @(posedge clk) #1;
    check("tx_start_pulse", 32'(tx_start), 1);
    check("tx_data_value", 32'(tx_data), 32'(8'(8'h30 + {4'b0000, d})));
    check("busy_at_tx", 32'(busy), 1);
    @(posedge clk) #1;
    check("tx_start_one_cycle", 32'(tx_start), 0);
    check("busy_after_tx", 32'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    rx_rdy     = 1'b0;
    rx_data    = 8'h00;
    core_done  = 1'b0;
    core_digit = 4'd0;
    tx_rdy     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_data", 32'(ram_data), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_digit", 32'(digit), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    load_image(1'b0, 20, 1);

    @(posedge clk) #1;
    rx_rdy  = 1'b1;
    rx_data = 8'hFF;
    @(posedge clk) #1;
    rx_rdy = 1'b0;
    repeat (3) @(posedge clk);

    classify(4'd7, 0);

    @(posedge clk) #1;
    core_done  = 1'b1;
    core_digit = 4'd5;
    @(posedge clk) #1;
    core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("digit_ignored_in_load", 32'(digit), 7);
    check("busy_idle", 32'(busy), 0);

    load_image(1'b1, 9, 2);
    classify(4'd3, 50);

    for (int k = 0; k < 49; k++)
      send_byte(8'($urandom), 12, 1'b0);
    @(posedge clk) #1;
    rx_rdy  = 1'b1;
    rx_data = 8'($urandom);
    exp_wr.push_back({10'(next_addr), rx_data[0]});
    @(posedge clk) #1;
    rx_rdy = 1'b0;
    rst    = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    check("rst_mid_ram_we", 32'(ram_we), 0);
    check("rst_mid_ram_addr", 32'(ram_addr), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_pending_writes", exp_wr.size(), 0);
    next_addr = 0;

    load_image(1'b1, 12, 3);
    classify(4'd0, 0);
    load_image(1'b1, 10, 4);
    classify(4'd9, 0);

    repeat (5) @(posedge clk);
    #1;
    check("writes_left", exp_wr.size(), 0);
    check("tx_left", exp_tx.size(), 0);
    check("start_total", n_start, 4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snn_image_loader.md
# snn_image_loader

Host-side front end for the SNN digit classifier. Receives a 784-pixel binary image as 98 packed bytes from the UART receiver, unpacks it one bit per cycle into the input-unit RAM that the core reads, pulses the core's `start`, waits for `done`, then sends the classified digit back through the UART transmitter as an ASCII character.

## Interface
Parameters:
- NUM_PIXELS, 784, pixels per image; must be a multiple of 8. NUM_BYTES = NUM_PIXELS/8 = 98.
- ASCII_BASE, 8'h30, offset added to the digit for the transmitted character.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_rdy  in  1  one-cycle strobe: `rx_data` holds a new byte.
- rx_data  in  8  received byte. Bit 0 is the lowest-addressed pixel.
- ram_addr  out  10  input-unit RAM write address.
- ram_data  out  1  input-unit RAM write data (pixel bit).
- ram_we  out  1  input-unit RAM write enable.
- core_start  out  1  one-cycle start pulse to the SNN core.
- core_done  in  1  one-cycle done pulse from the SNN core.
- core_digit  in  4  core result; valid while `core_done` is high.
- tx_rdy  in  1  transmitter idle; it can accept a byte.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  byte to transmit; held stable from `tx_start` until the next `tx_start`.
- digit  out  4  last classified digit; held until the next result.
- busy  out  1  high in every state except LOAD.

## Operation
- States and transitions:
  - LOAD: wait for a byte. `rx_rdy` latches `rx_data` into an 8-bit shift register, clears the bit counter and moves to UNPACK.
  - UNPACK: eight cycles. Each cycle writes shreg[0] to `ram_addr` with `ram_we`=1, shifts right and increments `ram_addr`.
    - After bit 7, if `ram_addr` has just written NUM_PIXELS-1, go to START. Otherwise return to LOAD.
  - START: drive `core_start`=1 for one cycle. Clear `ram_addr` to 0. Go to WAIT_DONE.
  - WAIT_DONE: on `core_done`, latch `core_digit` into `digit` and go to SEND.
  - SEND: when `tx_rdy` is high, drive `tx_start`=1 and `tx_data` = ASCII_BASE + {4'b0, digit` latched value}. Go to LOAD. While `tx_rdy` is low, stay in SEND.
- `ram_addr` is a 10-bit counter. It counts 0..783 across the whole image and is not reset between bytes. It does not wrap past 783; START clears it.
- `tx_data` arithmetic is 8-bit with no clamp. A digit value of 10–15 produces 8'h3A–8'h3F.
- Dropped inputs:
  - `rx_rdy` in UNPACK, START, WAIT_DONE or SEND is dropped. The shift register, counter and RAM are unaffected.
  - `core_done` outside WAIT_DONE is ignored.
- `core_done` arriving in the same cycle that START is entered is not accepted; acceptance starts in WAIT_DONE.
- Reset at any point, including mid-UNPACK or mid-WAIT_DONE, returns to LOAD with `ram_addr`=0. A partially loaded image is discarded; the next byte is written from address 0.

## Timing
- Reset values: state LOAD, ram_addr 0, ram_data 0, ram_we 0, core_start 0, tx_start 0, tx_data 8'h00, digit 0, busy 0.
- All outputs are registered or decoded from registered state. No input-to-output combinational path.
- `rx_rdy` sampled high at edge N (in LOAD): `ram_we`=1 during cycles N+1..N+8, with ram_data = byte bit 0..7 and ram_addr = base..base+7.
  - The earliest next byte is accepted at edge N+9. Minimum byte spacing is 9 cycles.
- Last write (addr 783) in cycle M: `core_start`=1 in cycle M+1; `busy` stays high.
- `core_done` sampled at edge D: `digit` is updated in cycle D+1 and the FSM is in SEND at D+1.
  - If `tx_rdy`=1 in cycle D+1, `tx_start`=1 in cycle D+2.
  - In general, `tx_start` follows one cycle after the first cycle in SEND with `tx_rdy`=1.
- `busy` falls in the cycle after `tx_start`.

## Test plan
- Full load, pattern: 98 bytes 8'hA5, spaced 20 cycles apart.
  - -> 784 writes, addr 0..783 in order, data 1,0,1,0,0,1,0,1 repeating per byte.
  - -> exactly one `core_start` pulse, one cycle after the addr-783 write.
- Result path: after load, pulse `core_done` with `core_digit`=7 and hold `tx_rdy`=1.
  - -> `digit`=7 next cycle; `tx_start` one cycle later with `tx_data`=8'h37; `busy` low in the following cycle.
- Transmitter backpressure: `core_digit`=3 with `tx_rdy`=0 for 50 cycles, then 1.
  - -> no `tx_start` while `tx_rdy` is low; `tx_data`=8'h33 one cycle after `tx_rdy` rises.
- Dropped traffic:
  - `rx_rdy` 3 cycles after an accepted byte -> no extra writes; the address sequence stays contiguous.
  - `rx_rdy` during WAIT_DONE -> no RAM writes.
  - `core_done` during LOAD -> `digit` unchanged, no `tx_start`.
- Reset mid-operation:
  - Assert `rst` for one cycle during the 50th byte's UNPACK -> `ram_we` low the next cycle.
  - A fresh 98-byte load then writes from addr 0 and produces one `core_start`.
- Back-to-back images: two complete load/classify cycles returning digits 0 then 9.
  - -> `tx_data` 8'h30 then 8'h39; the second image's writes start at addr 0.
